// File: rtl/smpl_cqueue.sv
// rtl/smpl_cqueue.sv - circular stereo sample queue feeding the FIR stage with oldest-first bursts.
// Optional sticky lost-burst flag `ovf` when SMPL_CQUEUE_OVF_DET_EN is defined.
module smpl_cqueue #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int SEQ_LEN = 1021
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out
`ifdef SMPL_CQUEUE_OVF_DET_EN
  ,
  output logic               ovf
`endif
);

  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(SEQ_LEN);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SEQ_LEN - 1);
  localparam logic [AW-1:0] WIN_OFF   = AW'(SEQ_LEN);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t state, state_nxt;
  logic [AW-1:0] new_ptr, rd_ptr, rd_addr;
  logic [CW-1:0] cnt, cnt_inc, slot;
  logic pend, rd_en, burst_start;

  logic signed [15:0] lft_mem  [DEPTH];
  logic signed [15:0] rght_mem [DEPTH];

  assign cnt_inc    = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);
  assign sequencing = (state == SEQ);

  // The window start is taken from new_ptr at burst start, so later writes cannot move it.
  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr;
    burst_start = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          state_nxt   = SEQ;
          rd_en       = 1'b1;
          rd_addr     = new_ptr - WIN_OFF;
          burst_start = 1'b1;
        end
      end
      SEQ: begin
        if (slot == SLOT_LAST) state_nxt = IDLE;
        else                   rd_en     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wrt_smpl) begin
      lft_mem[new_ptr]  <= lft_smpl;
      rght_mem[new_ptr] <= rght_smpl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      new_ptr  <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      slot     <= '0;
      pend     <= 1'b0;
      lft_out  <= '0;
      rght_out <= '0;
    end else begin
      state <= state_nxt;
      if (wrt_smpl) begin
        new_ptr <= new_ptr + AW'(1);
        cnt     <= cnt_inc;
      end
      // A write landing on the burst-start edge needs its own burst, so set wins.
      if (wrt_smpl && (cnt_inc == CNT_FULL)) pend <= 1'b1;
      else if (burst_start)                  pend <= 1'b0;
      if (burst_start)  slot <= '0;
      else if (rd_en)   slot <= slot + CW'(1);
      if (rd_en) begin
        rd_ptr   <= rd_addr + AW'(1);
        lft_out  <= lft_mem[rd_addr];
        rght_out <= rght_mem[rd_addr];
      end
    end
  end

`ifdef SMPL_CQUEUE_OVF_DET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       ovf <= 1'b0;
    else if (wrt_smpl && pend && (state == SEQ))   ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_smpl_cqueue.sv
// tb/tb_smpl_cqueue.sv - scoreboard bench for smpl_cqueue (small and default geometry).
module tb_smpl_cqueue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic wrt_a, wrt_b;
  logic signed [15:0] lin_a, rin_a, lout_a, rout_a;
  logic signed [15:0] lin_b, rin_b, lout_b, rout_b;
  logic seq_a, seq_b;
`ifdef SMPL_CQUEUE_OVF_DET_EN
  logic ovf_a, ovf_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  smpl_cqueue #(.DEPTH(8), .AW(3), .SEQ_LEN(5)) dut_a (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_a), .lft_smpl(lin_a), .rght_smpl(rin_a),
    .sequencing(seq_a), .lft_out(lout_a), .rght_out(rout_a)
`ifdef SMPL_CQUEUE_OVF_DET_EN
    , .ovf(ovf_a)
`endif
  );

  smpl_cqueue dut_b (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_b), .lft_smpl(lin_b), .rght_smpl(rin_b),
    .sequencing(seq_b), .lft_out(lout_b), .rght_out(rout_b)
`ifdef SMPL_CQUEUE_OVF_DET_EN
    , .ovf(ovf_b)
`endif
  );

  always @(negedge clk) begin
    logic [31:0] e;
    if (seq_a) begin
      vectors++;
      if (exp_a.size() == 0) begin
        miscompares++;
        $display("FAIL mon_a unexpected slot got L=%0d R=%0d required no burst", lout_a, rout_a);
      end else begin
        e = exp_a.pop_front();
        if ({lout_a, rout_a} !== e) begin
          miscompares++;
          $display("FAIL mon_a slot got %h required %h", {lout_a, rout_a}, e);
        end
      end
    end
    if (seq_b) begin
      vectors++;
      if (exp_b.size() == 0) begin
        miscompares++;
        $display("FAIL mon_b unexpected slot got L=%0d required no burst", lout_b);
      end else begin
        e = exp_b.pop_front();
        if ({lout_b, rout_b} !== e) begin
          miscompares++;
          $display("FAIL mon_b slot got %h required %h", {lout_b, rout_b}, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int l, input int r);
    wrt_a = 1'b1;
    lin_a = 16'(l);
    rin_a = 16'(r);
    @(posedge clk);
    #1;
    wrt_a = 1'b0;
  endtask

  task automatic push_win(input int first, input int last);
    for (int k = first; k <= last; k++) exp_a.push_back({16'(k), 16'(-k)});
  endtask

  task automatic burst_len(input bit sel_b, output int len);
    len = 0;
    while ((sel_b ? seq_b : seq_a) && len < 3000) begin
      @(posedge clk);
      #1;
      len++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wrt_a = 1'b0;
    wrt_b = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  // Expects the caller has just returned from the triggering write.
  task automatic check_burst(input string tag, input int want_len);
    int len;
    vectors++;
    if (seq_a !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_rise got %b required 0", tag, seq_a);
    end
    idle(1);
    vectors++;
    if (seq_a !== 1'b1) begin
      miscompares++;
      $display("FAIL %s rise got %b required 1", tag, seq_a);
    end
    burst_len(1'b0, len);
    vectors++;
    if (len !== want_len) begin
      miscompares++;
      $display("FAIL %s burst_len got %0d required %0d", tag, len, want_len);
    end
  endtask

  task automatic fill_four(input int base);
    for (int k = base; k < base + 4; k++) begin
      do_write(k, -k);
      idle(3);
      vectors++;
      if (seq_a !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_no_burst_%0d got %b required 0", k, seq_a);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wrt_a = 1'b0; wrt_b = 1'b0;
    lin_a = '0; rin_a = '0; lin_b = '0; rin_b = '0;
    #1;
    vectors++;
    if ({seq_a, lout_a, rout_a, seq_b, lout_b, rout_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs got %b/%0d/%0d required 0/0/0", seq_a, lout_a, rout_a);
    end
`ifdef SMPL_CQUEUE_OVF_DET_EN
    vectors++;
    if (ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf got %b required 0", ovf_a);
    end
`endif
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_fill();
    fill_four(1);
    idle(16);
    push_win(1, 5);
    do_write(5, -5);
    check_burst("fill", 5);
    idle(15);
    vectors++;
    if (exp_a.size() !== 0) begin
      miscompares++;
      $display("FAIL fill_drain got %0d left required 0", exp_a.size());
    end
  endtask

  task automatic test_sliding();
    for (int k = 6; k <= 12; k++) begin
      push_win(k - 4, k);
      do_write(k, -k);
      check_burst($sformatf("slide_%0d", k), 5);
      idle(12);
    end
    vectors++;
    if (exp_a.size() !== 0) begin
      miscompares++;
      $display("FAIL slide_drain got %0d left required 0", exp_a.size());
    end
  endtask

  task automatic test_write_in_burst(input bit dbl);
    int n, len;
    do_reset();
    fill_four(1);
    push_win(1, 5);
    do_write(5, -5);
    idle(2);
    if (dbl) begin
      push_win(3, 7);
      do_write(6, -6);
      do_write(7, -7);
      n = 3;
    end else begin
      push_win(2, 6);
      do_write(6, -6);
      n = 2;
    end
    while (seq_a && n < 20) begin
      idle(1);
      n++;
    end
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL wib%0d first_len got %0d required 5", dbl, n);
    end
    idle(1);
    vectors++;
    if (seq_a !== 1'b1) begin
      miscompares++;
      $display("FAIL wib%0d gap got %b required 1 after one low cycle", dbl, seq_a);
    end
    burst_len(1'b0, len);
    vectors++;
    if (len !== 5) begin
      miscompares++;
      $display("FAIL wib%0d second_len got %0d required 5", dbl, len);
    end
    idle(20);
    vectors++;
    if (exp_a.size() !== 0) begin
      miscompares++;
      $display("FAIL wib%0d drain got %0d left required 0", dbl, exp_a.size());
    end
`ifdef SMPL_CQUEUE_OVF_DET_EN
    vectors++;
    if (ovf_a !== dbl) begin
      miscompares++;
      $display("FAIL wib%0d ovf got %b required %b", dbl, ovf_a, dbl);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    fill_four(1);
    push_win(1, 5);
    do_write(5, -5);
    idle(3);
    rst = 1'b1;
    #1;
    vectors++;
    if ({seq_a, lout_a, rout_a} !== '0) begin
      miscompares++;
      $display("FAIL rmb_async got %b/%0d/%0d required 0/0/0", seq_a, lout_a, rout_a);
    end
    exp_a.delete();
    idle(2);
    rst = 1'b0;
    idle(1);
    fill_four(21);
    idle(5);
    push_win(21, 25);
    do_write(25, -25);
    check_burst("rmb_refill", 5);
    idle(5);
    vectors++;
    if (exp_a.size() !== 0) begin
      miscompares++;
      $display("FAIL rmb_drain got %0d left required 0", exp_a.size());
    end
  endtask

  task automatic test_default_params();
    int len;
    logic signed [15:0] last_r;
    last_r = 16'(-1020);
    do_reset();
    for (int k = 0; k <= 1020; k++) exp_b.push_back({16'(k), 16'(-k)});
    for (int k = 0; k <= 1020; k++) begin
      wrt_b = 1'b1;
      lin_b = 16'(k);
      rin_b = 16'(-k);
      @(posedge clk);
      #1;
    end
    wrt_b = 1'b0;
    vectors++;
    if (seq_b !== 1'b0) begin
      miscompares++;
      $display("FAIL dflt_early got %b required 0", seq_b);
    end
    idle(1);
    vectors++;
    if (seq_b !== 1'b1) begin
      miscompares++;
      $display("FAIL dflt_rise got %b required 1", seq_b);
    end
    burst_len(1'b1, len);
    vectors++;
    if (len !== 1021) begin
      miscompares++;
      $display("FAIL dflt_len got %0d required 1021", len);
    end
    idle(5);
    vectors++;
    if (lout_b !== 16'sd1020 || rout_b !== last_r || exp_b.size() !== 0) begin
      miscompares++;
      $display("FAIL dflt_hold got L=%0d R=%0d left=%0d required 1020 -1020 0",
               lout_b, rout_b, exp_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_sliding();
    test_write_in_burst(1'b0);
    test_write_in_burst(1'b1);
    test_reset_mid_burst();
    test_default_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
